// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared FSM state enum and default width for the serial subtractor
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first unsigned subtractor, one bit per SHIFT cycle
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit;
  logic             br_next;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_next)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        // last bit: publish the fully shifted result and final borrow on the same edge
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = br_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with directed and random operations
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           errors = 0;
  int           checks = 0;
  logic [W:0]   sb[$];
  logic [W:0]   mon_e;
  logic [W-1:0] last_diff;
  logic         last_borrow;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: plain integer subtraction, borrow is an unsigned compare
  function automatic logic [W:0] model(input int x, input int y);
    int r;
    r = (x - y + (1 << W)) % (1 << W);
    return {(x < y) ? 1'b1 : 1'b0, r[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_exclusive", int'(bus.busy & bus.done), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("diff", int'(bus.diff), int'(mon_e[W-1:0]));
          chk("borrow", int'(bus.borrow), int'(mon_e[W]));
        end
      end
    end
  end

  // glitch bit k drives a spurious start (a=0, b=0x55) during cycle k after acceptance
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int glitch);
    logic [W:0] e;
    e = model(int'(x), int'(y));
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      chk("busy_window", int'(bus.busy), int'(k <= W));
      chk("done_latency", int'(bus.done), int'(k == W + 1));
      if (k <= W) begin
        chk("hold_diff", int'(bus.diff), int'(last_diff));
        chk("hold_borrow", int'(bus.borrow), int'(last_borrow));
      end
      @(posedge clk); #1;
      if (glitch[k+1]) begin
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = W'(8'h55);
      end else begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
    end
    bus.start   = 1'b0;
    last_diff   = e[W-1:0];
    last_borrow = e[W];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    last_diff   = '0;
    last_borrow = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_diff", int'(bus.diff), 0);
    chk("reset_borrow", int'(bus.borrow), 0);
    @(posedge clk); #1;

    op(8'h05, 8'h03, 0);
    op(8'h03, 8'h05, 0);
    op(8'h00, 8'hFF, 0);
    op(8'hAA, 8'hAA, 0);
    op(8'hFF, 8'h00, 0);
    op(8'h10, 8'h01, (1 << 4) | (1 << (W + 1)));
    op(8'h03, 8'h05, 0);

    // abort mid-operation: outputs clear and no done may follow
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_diff", int'(bus.diff), 0);
    chk("abort_borrow", int'(bus.borrow), 0);
    last_diff   = '0;
    last_borrow = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("abort_quiet_busy", int'(bus.busy), 0);
    end
    @(posedge clk); #1;
    op(8'h80, 8'h01, 0);

    // reset wins over a same-cycle start
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", int'(bus.busy), 0);
    chk("rst_prio_diff", int'(bus.diff), 0);
    last_diff   = '0;
    last_borrow = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 0);
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
